delay_sum_beamformer: RTL and testbench

DELAY_SUM_BEAMFORMER -- requirements
Module: delay_sum_beamformer

---
 rtl/delay_sum_beamformer.sv | 164 ++++++++++++++++
 tb/tb_delay_sum_beamformer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum receive beamformer: per-channel circular delay lines, shared write pointer, 2-stage sum pipeline.
// Optional macro OUTPUT_SAT_EN clamps dout to the signed DATA_WIDTH range (no added latency).
module delay_sum_beamformer #(
  parameter  int NUM_CH     = 8,
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 128,
  localparam int DW         = $clog2(DEPTH),
  localparam int SW         = DATA_WIDTH + $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         din_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic                         delay_load,
  input  logic [3:0]                   delay_ch,
  input  logic [6:0]                   delay_val,
  output logic                         dout_valid,
  output logic signed [SW-1:0]         dout,
  output logic                         frame_busy
);

  localparam int MAX_DELAY = DEPTH - 1;

  logic [DW-1:0]                  r_wrPtr;
  logic [DW-1:0]                  r_fill;
  logic [DW-1:0]                  r_delay [NUM_CH];
  logic signed [DATA_WIDTH-1:0]   r_mem   [NUM_CH][DEPTH];
  logic signed [DATA_WIDTH-1:0]   r_sel   [NUM_CH];
  logic                           r_v1;
  logic                           r_v2;
  logic signed [SW-1:0]           r_dout;
  logic                           r_busy;

  logic [DW-1:0]                  w_wrAddr;
  logic [DW-1:0]                  w_fill;
  logic [DW-1:0]                  w_delayClamp;
  logic                           w_delayWrite;
  logic [DW-1:0]                  w_rdAddr [NUM_CH];
  logic signed [DATA_WIDTH-1:0]   w_sel    [NUM_CH];
  logic signed [SW-1:0]           w_sum;
  logic signed [SW-1:0]           w_out;

  // A frame_start coinciding with din_valid makes that sample index 0 of the new frame.
  assign w_wrAddr = frame_start ? '0 : r_wrPtr;
  assign w_fill   = frame_start ? '0 : r_fill;

  assign w_delayClamp = (int'(delay_val) > MAX_DELAY) ? DW'(MAX_DELAY) : DW'(delay_val);
  assign w_delayWrite = delay_load && (int'(delay_ch) < NUM_CH);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_delay[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_delayWrite && (int'(delay_ch) == c)) begin
          r_delay[c] <= w_delayClamp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_fill  <= '0;
    end else if (din_valid) begin
      r_wrPtr <= w_wrAddr + DW'(1);
      r_fill  <= (w_fill == DW'(MAX_DELAY)) ? w_fill : w_fill + DW'(1);
    end else if (frame_start) begin
      r_wrPtr <= '0;
      r_fill  <= '0;
    end
  end

  // Delay RAM is never cleared; stale entries are masked by the fill counter instead.
  always_ff @(posedge clk) begin
    if (din_valid && !reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_mem[c][w_wrAddr] <= din[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_rdAddr[c] = w_wrAddr - r_delay[c];
      w_sel[c]    = '0;
      if (r_delay[c] == '0) begin
        w_sel[c] = din[c*DATA_WIDTH +: DATA_WIDTH];
      end else if (w_fill >= r_delay[c]) begin
        w_sel[c] = r_mem[c][w_rdAddr[c]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_sel[c] <= '0;
      end
    end else begin
      r_v1 <= din_valid;
      if (din_valid) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_sel[c] <= w_sel[c];
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum = w_sum + {{(SW-DATA_WIDTH){r_sel[c][DATA_WIDTH-1]}}, r_sel[c]};
    end
  end

`ifdef OUTPUT_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_WIDTH-1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DATA_WIDTH-1)));

  always_comb begin
    w_out = w_sum;
    if (w_sum > SAT_MAX) begin
      w_out = SAT_MAX;
    end else if (w_sum < SAT_MIN) begin
      w_out = SAT_MIN;
    end
  end
`else
  assign w_out = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v2   <= 1'b0;
      r_dout <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_dout <= w_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
    end else if (din_valid) begin
      r_busy <= 1'b1;
    end else if (frame_start) begin
      r_busy <= 1'b0;
    end
  end

  assign dout_valid = r_v2;
  assign dout       = r_dout;
  assign frame_busy = r_busy;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Directed self-checking bench for delay_sum_beamformer (8-channel default instance plus a small 2-channel instance).
module tb_delay_sum_beamformer;

  localparam int NCH  = 8;
  localparam int DWID = 16;
  localparam int DEP  = 128;
  localparam int SW1  = 19;
  localparam int NCH2 = 2;
  localparam int DEP2 = 16;
  localparam int SW2  = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset = 1'b0;
  logic                     frame_start = 1'b0;
  logic                     din_valid = 1'b0;
  logic [NCH*DWID-1:0]      din = '0;
  logic                     delay_load = 1'b0;
  logic [3:0]               delay_ch = '0;
  logic [6:0]               delay_val = '0;
  logic                     dout_valid;
  logic signed [SW1-1:0]    dout;
  logic                     frame_busy;

  logic                     d2_frame_start = 1'b0;
  logic                     d2_din_valid = 1'b0;
  logic [NCH2*DWID-1:0]     d2_din = '0;
  logic                     d2_delay_load = 1'b0;
  logic [3:0]               d2_delay_ch = '0;
  logic [6:0]               d2_delay_val = '0;
  logic                     d2_dout_valid;
  logic signed [SW2-1:0]    d2_dout;
  logic                     d2_frame_busy;

  int checks = 0;
  int failures = 0;
  int chv [NCH];

  delay_sum_beamformer #(.NUM_CH(NCH), .DATA_WIDTH(DWID), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .din_valid(din_valid), .din(din),
    .delay_load(delay_load), .delay_ch(delay_ch), .delay_val(delay_val),
    .dout_valid(dout_valid), .dout(dout), .frame_busy(frame_busy)
  );

  delay_sum_beamformer #(.NUM_CH(NCH2), .DATA_WIDTH(DWID), .DEPTH(DEP2)) dut2 (
    .clk(clk), .reset(reset), .frame_start(d2_frame_start), .din_valid(d2_din_valid), .din(d2_din),
    .delay_load(d2_delay_load), .delay_ch(d2_delay_ch), .delay_val(d2_delay_val),
    .dout_valid(d2_dout_valid), .dout(d2_dout), .frame_busy(d2_frame_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_chv();
    for (int c = 0; c < NCH; c++) chv[c] = 0;
  endtask

  task automatic drive(input logic fs);
    for (int c = 0; c < NCH; c++) din[c*DWID +: DWID] = DWID'(chv[c]);
    din_valid   = 1'b1;
    frame_start = fs;
    tick();
    din_valid   = 1'b0;
    frame_start = 1'b0;
    delay_load  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_delay(input int ch, input int val);
    delay_ch   = 4'(ch);
    delay_val  = 7'(val);
    delay_load = 1'b1;
    tick();
    delay_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", dout_valid); end
    checks++; if (dout !== '0) begin failures++; $display("[TB] FAIL reset_dout: got %0d expected 0", dout); end
    checks++; if (frame_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", frame_busy); end
    checks++; if (d2_dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid2: got %0b expected 0", d2_dout_valid); end
  endtask

  task automatic test_zero_delay();
    do_reset();
    for (int c = 0; c < NCH; c++) chv[c] = 100;
    drive(1'b1);
    clear_chv();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL zd_lat1_valid: got %0b expected 0", dout_valid); end
    checks++; if (frame_busy !== 1'b1) begin failures++; $display("[TB] FAIL zd_busy: got %0b expected 1", frame_busy); end
    tick();
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL zd_lat2_valid: got %0b expected 1", dout_valid); end
    checks++; if (dout !== SW1'(800)) begin failures++; $display("[TB] FAIL zd_sum: got %0d expected 800", dout); end
    tick();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL zd_lat3_valid: got %0b expected 0", dout_valid); end
    checks++; if (dout !== SW1'(800)) begin failures++; $display("[TB] FAIL zd_hold: got %0d expected 800", dout); end
  endtask

  task automatic test_delay_three();
    int expv [6] = '{7, 7, 7, 1007, 7, 7};
    do_reset();
    load_delay(0, 3);
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        clear_chv();
        chv[2] = 7;
        if (k == 0) chv[0] = 1000;
        drive(k == 0);
      end else begin
        tick();
      end
      if (k >= 1) begin
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL d3_valid k=%0d: got %0b expected 1", k-1, dout_valid); end
        checks++; if (dout !== SW1'(expv[k-1])) begin failures++; $display("[TB] FAIL d3_sum k=%0d: got %0d expected %0d", k-1, dout, expv[k-1]); end
      end
    end
  endtask

  task automatic test_delay_update();
    int e;
    do_reset();
    for (int k = 0; k <= 13; k++) begin
      if (k <= 12) begin
        clear_chv();
        chv[1] = 10 * k + 1;
        if (k == 10) begin
          delay_ch   = 4'd1;
          delay_val  = 7'd5;
          delay_load = 1'b1;
        end
        drive(k == 0);
      end else begin
        tick();
      end
      if (k >= 1) begin
        e = (k - 1 <= 10) ? 10 * (k - 1) + 1 : 10 * (k - 1 - 5) + 1;
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL upd_valid k=%0d: got %0b expected 1", k-1, dout_valid); end
        checks++; if (dout !== SW1'(e)) begin failures++; $display("[TB] FAIL upd_sum k=%0d: got %0d expected %0d", k-1, dout, e); end
      end
    end
  endtask

  task automatic test_clamp_ignore();
    int e;
    do_reset();
    load_delay(3, 127);
    load_delay(12, 9);
    for (int k = 0; k <= 129; k++) begin
      if (k <= 128) begin
        clear_chv();
        chv[0] = 20;
        chv[4] = 50;
        if (k == 0) chv[3] = 1000;
        drive(k == 0);
      end else begin
        tick();
      end
      if (k >= 1) begin
        e = (k - 1 == 127) ? 1070 : 70;
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL d127_valid k=%0d: got %0b expected 1", k-1, dout_valid); end
        checks++; if (dout !== SW1'(e)) begin failures++; $display("[TB] FAIL d127_sum k=%0d: got %0d expected %0d", k-1, dout, e); end
      end
    end
    // Small instance: 100 clamps to DEPTH-1 = 15, channel 2 is out of range.
    d2_delay_ch = 4'd1; d2_delay_val = 7'd100; d2_delay_load = 1'b1;
    tick();
    d2_delay_ch = 4'd2; d2_delay_val = 7'd1;
    tick();
    d2_delay_load = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      if (k <= 16) begin
        d2_din = {16'(k == 0 ? 500 : 0), 16'd9};
        d2_din_valid = 1'b1;
        d2_frame_start = (k == 0);
        tick();
        d2_din_valid = 1'b0;
        d2_frame_start = 1'b0;
      end else begin
        tick();
      end
      if (k >= 1) begin
        e = (k - 1 == 15) ? 509 : 9;
        checks++; if (d2_dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL clamp_valid k=%0d: got %0b expected 1", k-1, d2_dout_valid); end
        checks++; if (d2_dout !== SW2'(e)) begin failures++; $display("[TB] FAIL clamp_sum k=%0d: got %0d expected %0d", k-1, d2_dout, e); end
      end
    end
  endtask

  task automatic test_frame_restart();
    int kk;
    int e;
    do_reset();
    load_delay(0, 4);
    for (int n = 0; n <= 58; n++) begin
      if (n <= 57) begin
        clear_chv();
        chv[0] = 200;
        chv[1] = 3;
        drive(n == 0 || n == 50);
      end else begin
        tick();
      end
      if (n >= 1) begin
        kk = (n - 1 < 50) ? n - 1 : n - 1 - 50;
        e  = (kk >= 4) ? 203 : 3;
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL fr_valid n=%0d: got %0b expected 1", n-1, dout_valid); end
        checks++; if (dout !== SW1'(e)) begin failures++; $display("[TB] FAIL fr_sum n=%0d: got %0d expected %0d", n-1, dout, e); end
      end
    end
    checks++; if (frame_busy !== 1'b1) begin failures++; $display("[TB] FAIL fr_busy: got %0b expected 1", frame_busy); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (frame_busy !== 1'b0) begin failures++; $display("[TB] FAIL fr_busy_clear: got %0b expected 0", frame_busy); end
  endtask

  task automatic test_saturation();
    int ePos;
    int eNeg;
`ifdef OUTPUT_SAT_EN
    ePos = 32767;
    eNeg = -32768;
`else
    ePos = 262136;
    eNeg = -262144;
`endif
    do_reset();
    for (int c = 0; c < NCH; c++) chv[c] = 32767;
    drive(1'b1);
    for (int c = 0; c < NCH; c++) chv[c] = -32768;
    drive(1'b0);
    checks++; if (dout !== SW1'(ePos)) begin failures++; $display("[TB] FAIL sat_pos: got %0d expected %0d", dout, ePos); end
    tick();
    checks++; if (dout !== SW1'(eNeg)) begin failures++; $display("[TB] FAIL sat_neg: got %0d expected %0d", dout, eNeg); end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    for (int c = 0; c < NCH; c++) chv[c] = 1;
    drive(1'b1);
    for (int c = 0; c < NCH; c++) din[c*DWID +: DWID] = 16'd1;
    din_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    din_valid = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid: got %0b expected 0", dout_valid); end
    checks++; if (dout !== '0) begin failures++; $display("[TB] FAIL rst_mid_dout: got %0d expected 0", dout); end
    checks++; if (frame_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy: got %0b expected 0", frame_busy); end
    tick();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_flush1: got %0b expected 0", dout_valid); end
    tick();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_flush2: got %0b expected 0", dout_valid); end
    for (int c = 0; c < NCH; c++) chv[c] = 2;
    drive(1'b1);
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_new_lat1: got %0b expected 0", dout_valid); end
    tick();
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL rst_new_valid: got %0b expected 1", dout_valid); end
    checks++; if (dout !== SW1'(16)) begin failures++; $display("[TB] FAIL rst_new_sum: got %0d expected 16", dout); end
  endtask

  initial begin
    clear_chv();
    test_reset();
    test_zero_delay();
    test_delay_three();
    test_delay_update();
    test_clamp_ignore();
    test_frame_restart();
    test_saturation();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
